// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the receive and transmit paths.
package uart_pkg;

    localparam int unsigned UART_MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;

    // Parity bit a well-formed frame carries for the given data; data is zero-extended.
    function automatic logic calc_parity(input logic [UART_MAX_DATA_W-1:0] data,
                                         input parity_e                    mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronises rx_i, deserialises frames, checks parity/stop
// and buffers {frame_err, parity_err, data} in a FWFT FIFO for the command parser.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 30,
    parameter int unsigned DATA_W      = 8,
    parameter parity_e     PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          overrun_o,
    input  logic                          clear_i
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned HALF  = CLK_PER_BIT / 2;

    typedef struct packed {
        logic              frame_err;
        logic              parity_err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    logic           sync1_q, sync2_q, prev_q;
    logic           rx_s, fall;
    uart_rx_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_q;
    logic [DATA_W-1:0] shift_q;
    logic           perr_q, ferr_q;
    logic           push_q;
    rx_entry_t      entry_q;
    rx_entry_t      head;
    logic           full, empty, pop, drop;
    logic           mid_start, bit_end, stop_err;

    assign rx_s      = sync2_q;
    assign fall      = prev_q & ~sync2_q;
    assign mid_start = (cnt_q == CNT_W'(HALF));
    assign bit_end   = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
    assign stop_err  = ferr_q | ~rx_s;

    // Two-flop synchroniser plus edge-detect flop; idle-high after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame FSM: start is qualified at mid-bit, later bits every CLK_PER_BIT cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (mid_start) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            bit_q   <= '0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        perr_q  <= (rx_s != calc_parity(UART_MAX_DATA_W'(shift_q), PARITY));
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                            push_q             <= 1'b1;
                            entry_q.frame_err  <= stop_err;
                            entry_q.parity_err <= perr_q;
                            entry_q.data       <= shift_q;
                            state_q            <= stop_err ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            ferr_q <= stop_err;
                            bit_q  <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop  = valid_o & ready_i;
    assign drop = push_q & full & ~pop;

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_q),
        .data_i  (entry_q),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fill_o)
    );

    assign valid_o      = ~empty;
    assign data_o       = head.data;
    assign frame_err_o  = head.frame_err;
    assign parity_err_o = head.parity_err;

    // Sticky overrun; a drop in the same cycle as clear_i keeps it set.
    always_ff @(posedge clk_i) begin
        if (rst_i)        overrun_o <= 1'b0;
        else if (drop)    overrun_o <= 1'b1;
        else if (clear_i) overrun_o <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: two receivers (8N1 depth 8, 7E2 depth 4) fed serial frames,
// expected entries queued at send time and popped by per-instance monitors.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic clear_a = 1'b0, clear_b = 1'b0;
    int   ready_mode_a = 0, ready_mode_b = 0;

    logic [7:0] data_a;
    logic       ferr_a, perr_a, valid_a, ovr_a;
    logic [3:0] fill_a;
    logic [6:0] data_b;
    logic       ferr_b, perr_b, valid_b, ovr_b;
    logic [2:0] fill_b;

    uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_a), .data_o(data_a), .frame_err_o(ferr_a),
        .parity_err_o(perr_a), .valid_o(valid_a), .ready_i(ready_a), .fill_o(fill_a),
        .overrun_o(ovr_a), .clear_i(clear_a));

    uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_W(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_b), .data_o(data_b), .frame_err_o(ferr_b),
        .parity_err_o(perr_b), .valid_o(valid_b), .ready_i(ready_b), .fill_o(fill_b),
        .overrun_o(ovr_b), .clear_i(clear_b));

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];
    bit exp_ovr_a = 1'b0, exp_ovr_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
    endtask

    // Builds the serial frame from the line rules and queues the entry the receiver must report.
    task automatic send(input bit sel, input logic [7:0] data, input bit bad_par, input logic [1:0] stop_pat);
        bit          bits[$];
        int          dw = sel ? 7 : 8;
        logic [8:0]  d  = sel ? {2'b00, data[6:0]} : {1'b0, data};
        logic        ferr = sel ? ~(stop_pat[0] & stop_pat[1]) : ~stop_pat[0];
        logic        perr = sel ? bad_par : 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(d[i]);
        if (sel) bits.push_back((^d) ^ bad_par);
        bits.push_back(stop_pat[0]);
        if (sel) bits.push_back(stop_pat[1]);
        if (sel) begin
            if (exp_b.size() < 4) exp_b.push_back({ferr, perr, d});
            else exp_ovr_b = 1'b1;
        end else begin
            if (exp_a.size() < 8) exp_a.push_back({ferr, perr, d});
            else exp_ovr_a = 1'b1;
        end
        foreach (bits[i]) begin
            set_rx(sel, bits[i]);
            cyc(CPB);
        end
        set_rx(sel, 1'b1);
        cyc(2 * CPB);
    endtask

    task automatic drain(input bit sel, input string name);
        for (int i = 0; i < 3000; i++) begin
            if ((sel ? exp_b.size() : exp_a.size()) == 0) break;
            cyc(1);
        end
        chk(name, sel ? exp_b.size() : exp_a.size(), 0);
        cyc(5);
    endtask

    always begin
        @(posedge clk); #1;
        ready_a = (ready_mode_a == 2) ? 1'($urandom_range(0, 1)) : (ready_mode_a == 1);
        ready_b = (ready_mode_b == 2) ? 1'($urandom_range(0, 1)) : (ready_mode_b == 1);
    end

    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_a unexpected entry got 0x%0h expected none", {ferr_a, perr_a, 9'(data_a)});
            end else begin
                chk("mon_a", {ferr_a, perr_a, 9'(data_a)}, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_b unexpected entry got 0x%0h expected none", {ferr_b, perr_b, 9'(data_b)});
            end else begin
                chk("mon_b", {ferr_b, perr_b, 9'(data_b)}, exp_b.pop_front());
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen, done;
        cyc(3);
        @(negedge clk);
        chk("rst_valid", valid_a, 0);
        chk("rst_fill", fill_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_errs", {ferr_a, perr_a}, 0);
        chk("rst_b", {valid_b, fill_b, ovr_b, data_b, ferr_b, perr_b}, 0);
        cyc(1);
        rst = 1'b0;
        cyc(5);

        // Case 1: 8N1 0xA5 with latency from the start edge to valid_o
        ready_mode_a = 1;
        cyc(3);
        lat = 0;
        fork
            send(1'b0, 8'hA5, 1'b0, 2'b11);
            begin
                while (lat < 400) begin
                    @(negedge clk);
                    lat++;
                    if (valid_a) break;
                end
            end
        join
        checks++;
        if (lat < 289 || lat > 293) begin
            errors++;
            $display("FAIL case1_latency: got %0d cycles expected 289..293", lat);
        end
        drain(1'b0, "case1_drain");

        // Case 3: short glitch never produces an entry
        rx_a = 1'b0; cyc(10); rx_a = 1'b1; cyc(100);
        @(negedge clk);
        chk("glitch_valid", valid_a, 0);
        chk("glitch_fill", fill_a, 0);
        cyc(1);

        // Case 4: break produces one frame-error entry of zero data
        exp_a.push_back({1'b1, 1'b0, 9'h000});
        rx_a = 1'b0;
        cyc(20 * CPB);
        chk("break_entry_seen", exp_a.size(), 0);
        chk("break_fill", fill_a, 0);
        rx_a = 1'b1;
        cyc(100);
        chk("break_no_more", valid_a, 0);

        // Randomised traffic on A
        ready_mode_a = 2;
        for (int i = 0; i < 20; i++)
            send(1'b0, 8'($urandom), 1'b0, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11);
        ready_mode_a = 1;
        drain(1'b0, "rand_a_drain");
        chk("rand_a_overrun", ovr_a, exp_ovr_a);

        // Case 5: overrun with consumer stalled
        ready_mode_a = 0;
        cyc(3);
        for (int i = 1; i <= 9; i++) send(1'b0, 8'(i), 1'b0, 2'b11);
        chk("ovr_fill", fill_a, exp_a.size());
        chk("ovr_flag", ovr_a, exp_ovr_a);
        ready_mode_a = 1;
        drain(1'b0, "ovr_drain");
        chk("ovr_sticky", ovr_a, 1);
        clear_a = 1'b1; cyc(1); clear_a = 1'b0; cyc(1);
        exp_ovr_a = 1'b0;
        chk("ovr_cleared", ovr_a, exp_ovr_a);

        // Case 2: 7E2 with a wrong parity bit
        ready_mode_b = 1;
        cyc(3);
        send(1'b1, 8'h55, 1'b1, 2'b11);
        drain(1'b1, "parity_drain");

        // Randomised traffic on B
        ready_mode_b = 2;
        for (int i = 0; i < 20; i++)
            send(1'b1, 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11);
        ready_mode_b = 1;
        drain(1'b1, "rand_b_drain");
        chk("rand_b_overrun", ovr_b, exp_ovr_b);

        // Overrun set while clear_i is held: set must win for at least one cycle
        ready_mode_b = 0;
        clear_b = 1'b1;
        seen = 1'b0; done = 1'b0;
        cyc(3);
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h10 + i), 1'b0, 2'b11);
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 4000 && !done; c++) begin
                    @(negedge clk);
                    if (ovr_b) seen = 1'b1;
                end
            end
        join
        chk("set_beats_clear", seen, exp_ovr_b);
        clear_b = 1'b0;
        exp_ovr_b = 1'b0;
        chk("b_full_fill", fill_b, exp_b.size());
        chk("b_ovr_after_clear", ovr_b, exp_ovr_b);
        ready_mode_b = 1;
        drain(1'b1, "b_ovr_drain");

        // Case 6: reset during data bit 3 of 0x3C, then a clean 0x3C
        rx_a = 1'b0; cyc(CPB);
        rx_a = 1'b0; cyc(CPB);
        rx_a = 1'b0; cyc(CPB);
        rx_a = 1'b1; cyc(CPB);
        rx_a = 1'b1; cyc(CPB / 2);
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(2 * CPB);
        @(negedge clk);
        chk("abort_fill", fill_a, 0);
        chk("abort_valid", valid_a, 0);
        cyc(1);
        send(1'b0, 8'h3C, 1'b0, 2'b11);
        drain(1'b0, "after_reset_drain");
        chk("after_reset_overrun", ovr_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
